// File: rtl/video_in_capture.sv
// video_in_capture
//   Receive side of a parallel camera-style video interface. The pixel clock
//   is treated as data: it is oversampled in the clk domain, and pixel_in,
//   frame_valid and line_valid are sampled on each detected falling edge.
//   Pixels are packed four per 32-bit word and the words are written to a
//   downstream FIFO. Line length and frame height are checked.
//
// Ports
//   clk          system clock; all logic runs on it
//   nRST         asynchronous active-low reset
//   clk_in       pixel clock from the source (asynchronous, <= clk/4)
//   pixel_in     8-bit pixel from the source
//   frame_valid  frame active from the source
//   line_valid   line active from the source
//   w_en         one-cycle FIFO write strobe
//   w_data       packed word, first pixel of the group in [7:0]
//   fifo_full    FIFO cannot accept a write this cycle
//   clear        synchronous clear of the sticky status flags
//   frame_done   one-cycle pulse at the end of each captured frame
//   line_err     sticky: a line ended with a pixel count other than p_WIDTH
//   frame_err    sticky: a frame ended with a line count other than p_HEIGHT
//   overflow     sticky: a word was dropped because fifo_full was high
//   frame_cnt    (only with VIDEO_IN_FRAME_CNT_EN) count of frame_done pulses
//
// Optional feature macro: VIDEO_IN_FRAME_CNT_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | after reset; wait for fv=0 so capture starts on a frame boundary
// IDLE  | between frames; wait for fv=1
// LINE  | inside a line; every lv=1 sample is a pixel
// GAP   | inside a frame, between lines
module video_in_capture #(
    parameter int p_WIDTH  = 640,
    parameter int p_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        clk_in,
    input  logic [7:0]  pixel_in,
    input  logic        frame_valid,
    input  logic        line_valid,
    output logic        w_en,
    output logic [31:0] w_data,
    input  logic        fifo_full,
    input  logic        clear,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic        overflow
`ifdef VIDEO_IN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {SYNC, IDLE, LINE, GAP} state_t;

    state_t      state, state_nx;
    logic [2:0]  clk_in_sr;
    logic        smp;
    logic        smp_vld;
    logic [7:0]  smp_pix;
    logic        smp_fv;
    logic        smp_lv;
    logic [10:0] pix_cnt, pix_cnt_nx;
    logic [9:0]  line_cnt, line_cnt_nx;
    logic [23:0] pack, pack_nx;
    logic        capture;
    logic        wr_set;
    logic        wr_pend;
    logic        done_set;
    logic        line_err_set;
    logic        frame_err_set;

    // [0],[1] synchronize clk_in; [2] is the previous synced value.
    assign smp = clk_in_sr[2] & ~clk_in_sr[1];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            clk_in_sr <= '0;
            smp_vld   <= 1'b0;
            smp_pix   <= '0;
            smp_fv    <= 1'b0;
            smp_lv    <= 1'b0;
        end else begin
            clk_in_sr <= {clk_in_sr[1:0], clk_in};
            smp_vld   <= smp;
            if (smp) begin
                smp_pix <= pixel_in;
                smp_fv  <= frame_valid;
                smp_lv  <= line_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= SYNC;
            pix_cnt  <= '0;
            line_cnt <= '0;
            pack     <= '0;
        end else begin
            state    <= state_nx;
            pix_cnt  <= pix_cnt_nx;
            line_cnt <= line_cnt_nx;
            pack     <= pack_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pix_cnt_nx    = pix_cnt;
        line_cnt_nx   = line_cnt;
        pack_nx       = pack;
        capture       = 1'b0;
        wr_set        = 1'b0;
        done_set      = 1'b0;
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;
        if (smp_vld) begin
            case (state)
                SYNC: begin
                    if (!smp_fv) state_nx = IDLE;
                end
                IDLE: begin
                    line_cnt_nx = '0;
                    pix_cnt_nx  = '0;
                    if (smp_fv) begin
                        if (smp_lv) begin
                            capture  = 1'b1;
                            state_nx = LINE;
                        end else begin
                            state_nx = GAP;
                        end
                    end
                end
                LINE: begin
                    if (smp_lv && smp_fv) begin
                        capture = 1'b1;
                    end else begin
                        // Line end; a partial word is dropped with the pack register.
                        line_err_set = (pix_cnt != 11'(p_WIDTH));
                        line_cnt_nx  = line_cnt + 10'd1;
                        pix_cnt_nx   = '0;
                        pack_nx      = '0;
                        if (!smp_fv) begin
                            done_set      = 1'b1;
                            frame_err_set = (line_cnt_nx != 10'(p_HEIGHT));
                            state_nx      = IDLE;
                        end else begin
                            state_nx = GAP;
                        end
                    end
                end
                GAP: begin
                    if (!smp_fv) begin
                        done_set      = 1'b1;
                        frame_err_set = (line_cnt != 10'(p_HEIGHT));
                        state_nx      = IDLE;
                    end else if (smp_lv) begin
                        capture  = 1'b1;
                        state_nx = LINE;
                    end
                end
                default: state_nx = SYNC;
            endcase
        end
        // pix_cnt is always 0 when entering a line, so lane 0 takes the first pixel.
        if (capture) begin
            pix_cnt_nx = pix_cnt + 11'd1;
            if (pix_cnt[1:0] == 2'd3) begin
                wr_set  = 1'b1;
                pack_nx = '0;
            end else begin
                pack_nx[8*pix_cnt[1:0] +: 8] = smp_pix;
            end
        end
    end

    // The write strobe is gated by fifo_full in the same cycle it is offered.
    assign w_en = wr_pend & ~fifo_full;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_pend    <= 1'b0;
            w_data     <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_pend    <= wr_set;
            if (wr_set) w_data <= {smp_pix, pack};
            frame_done <= done_set;
            // Set has priority over clear.
            line_err   <= line_err_set  | (line_err  & ~clear);
            frame_err  <= frame_err_set | (frame_err & ~clear);
            overflow   <= (wr_pend & fifo_full) | (overflow & ~clear);
        end
    end

`ifdef VIDEO_IN_FRAME_CNT_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) frame_cnt <= '0;
        else if (done_set) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
